// File: rtl/trig_capture_buf.sv
// Triggered waveform capture buffer. It records DEPTH samples around a
// level/edge trigger, with a programmable pre-trigger depth and auto,
// normal or single trigger modes. The frame is frozen for display readout
// and restarts on the rd_done handshake.
module trig_capture_buf #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 800,
  parameter int ADDR_W       = 10,
  parameter int TO_W         = 24,
  parameter int AUTO_TIMEOUT = 100000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [1:0]        trig_mode,
  input  logic [ADDR_W-1:0] pre_trig,
  input  logic              arm,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_ready,
  output logic              frame_trig,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ARM = 3'd1,
    PRE_FILL = 3'd2,
    ARMED    = 3'd3,
    POST     = 3'd4,
    HOLD     = 3'd5
  } state_t;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [TO_W-1:0]   TO_LIM  = TO_W'(AUTO_TIMEOUT);

  state_t state, state_n;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wp, tp, start_ptr, cnt, p_lat;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] prev, lvl;
  logic              prev_valid, edg, ftn;
  logic [1:0]        mode;

  logic              accept, edge_hit, timeout_hit, trig_now;
  logic              frame_start, enter_hold, trig_flag;
  logic [ADDR_W-1:0] wp_next, p_in, post_len, trig_ptr, start_n, rd_ptr;
  logic [ADDR_W:0]   trig_x, p_x, start_x, sum_x, diff_x;

  assign state_o = state;

  // Datapath decode: sample acceptance, trigger detection, pointer math.
  always_comb begin
    accept   = sample_valid &&
               (state == PRE_FILL || state == ARMED || state == POST);
    wp_next  = (wp == LAST) ? '0 : wp + ADDR_W'(1);
    p_in     = (pre_trig > LAST) ? LAST : pre_trig;
    post_len = LAST - p_lat;
    edge_hit = prev_valid &&
               (edg ? (prev > lvl && sample_data <= lvl)
                    : (prev < lvl && sample_data >= lvl));
    timeout_hit = (mode == 2'd0) && (to_cnt + TO_W'(1) == TO_LIM);
    trig_now    = (state == ARMED) && accept && (edge_hit || timeout_hit);
    trig_flag   = trig_now ? edge_hit : ftn;
    // ARMED can go straight to HOLD when no post samples remain, so the
    // trigger pointer is taken from wp in that same cycle.
    trig_ptr = (state == ARMED) ? wp : tp;
    trig_x   = {1'b0, trig_ptr};
    p_x      = {1'b0, p_lat};
    start_x  = (trig_x >= p_x) ? trig_x - p_x : trig_x + DEPTH_X - p_x;
    start_n  = start_x[ADDR_W-1:0];
    sum_x    = {1'b0, start_ptr} + {1'b0, rd_addr};
    diff_x   = sum_x - DEPTH_X;
    if (rd_addr > LAST)
      rd_ptr = start_ptr;
    else if (sum_x >= DEPTH_X)
      rd_ptr = diff_x[ADDR_W-1:0];
    else
      rd_ptr = sum_x[ADDR_W-1:0];
  end

  // Next-state logic and frame-start decode.
  always_comb begin
    state_n     = state;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (trig_mode == 2'd2) begin
          state_n = WAIT_ARM;
        end else begin
          state_n     = PRE_FILL;
          frame_start = 1'b1;
        end
      end
      WAIT_ARM: begin
        if (arm) begin
          state_n     = PRE_FILL;
          frame_start = 1'b1;
        end
      end
      PRE_FILL: begin
        if (p_lat == '0)
          state_n = ARMED;
        else if (accept && (cnt + ADDR_W'(1) == p_lat))
          state_n = ARMED;
      end
      ARMED: begin
        if (trig_now)
          state_n = (p_lat == LAST) ? HOLD : POST;
      end
      POST: begin
        if (accept && (cnt + ADDR_W'(1) == post_len))
          state_n = HOLD;
      end
      HOLD: begin
        if (rd_done) begin
          if (mode == 2'd2) begin
            state_n = WAIT_ARM;
          end else begin
            state_n     = PRE_FILL;
            frame_start = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    enter_hold = (state_n == HOLD) && (state != HOLD);
  end

  // State, counters, pointers and latched frame configuration.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wp          <= '0;
      tp          <= '0;
      start_ptr   <= '0;
      cnt         <= '0;
      p_lat       <= '0;
      to_cnt      <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      lvl         <= '0;
      edg         <= 1'b0;
      mode        <= '0;
      ftn         <= 1'b0;
      frame_ready <= 1'b0;
      frame_trig  <= 1'b0;
    end else begin
      state       <= state_n;
      frame_ready <= enter_hold;
      if (enter_hold) begin
        frame_trig <= trig_flag;
        start_ptr  <= start_n;
      end
      if (accept) begin
        wp         <= wp_next;
        prev       <= sample_data;
        prev_valid <= 1'b1;
      end
      case (state)
        PRE_FILL: if (accept) cnt <= cnt + ADDR_W'(1);
        ARMED: begin
          if (trig_now) begin
            tp  <= wp;
            ftn <= edge_hit;
            cnt <= '0;
          end else if (accept && mode == 2'd0) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        POST: if (accept) cnt <= cnt + ADDR_W'(1);
        default: ;
      endcase
      if (frame_start) begin
        lvl        <= trig_level;
        edg        <= trig_edge;
        mode       <= trig_mode;
        p_lat      <= p_in;
        cnt        <= '0;
        to_cnt     <= '0;
        prev_valid <= 1'b0;
      end
    end
  end

  // Sample storage write port.
  always_ff @(posedge sys_clk) begin
    if (accept)
      mem[wp[IDX_W-1:0]] <= sample_data;
  end

  // Registered frame readout relative to the oldest frame sample.
  always_ff @(posedge sys_clk) begin
    if (!rst_n)
      rd_data <= '0;
    else
      rd_data <= mem[rd_ptr[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_trig_capture_buf.sv
// Directed bench for trig_capture_buf with a read-data scoreboard.
module tb_trig_capture_buf;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 6;
  localparam int TO = 20;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic [DW-1:0] trig_level = 8'h80;
  logic          trig_edge = 1'b0;
  logic [1:0]    trig_mode = 2'd1;
  logic [AW-1:0] pre_trig = 6'd4;
  logic          arm = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_done = 1'b0;
  logic [DW-1:0] rd_data;
  logic          frame_ready, frame_trig;
  logic [2:0]    state_o;

  int errors = 0;
  int checks = 0;
  int fr_cnt = 0;
  logic [7:0] stim [1024];
  logic [7:0] exp_q [$];

  trig_capture_buf #(
    .DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .TO_W(8), .AUTO_TIMEOUT(TO)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sample_data(sample_data), .trig_level(trig_level), .trig_edge(trig_edge),
    .trig_mode(trig_mode), .pre_trig(pre_trig), .arm(arm), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_data(rd_data), .frame_ready(frame_ready),
    .frame_trig(frame_trig), .state_o(state_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    if (frame_ready === 1'b1) fr_cnt++;
  endtask

  task automatic do_reset(input logic [2:0] st_after);
    rst_n = 1'b0;
    step();
    step();
    chk("rst state", state_o, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst frame_ready", frame_ready, 0);
    chk("rst frame_trig", frame_trig, 0);
    rst_n = 1'b1;
    step();
    chk("post-rst state", state_o, st_after);
  endtask

  task automatic fill_ramp(input int st, input int stp);
    for (int i = 0; i < 1024; i++) stim[i] = 8'(st + i * stp);
  endtask

  // Reference trigger search over the stimulus stream.
  task automatic find_trig(input int p, input logic [7:0] lvl, input bit edg,
                           input bit auto_m, output int k, output bit hit);
    int tcnt;
    bit e;
    tcnt = 0; k = -1; hit = 1'b0;
    for (int i = p; i < 1024; i++) begin
      e = (i >= 1) && (edg ? (stim[i-1] > lvl && stim[i] <= lvl)
                           : (stim[i-1] < lvl && stim[i] >= lvl));
      if (e) begin k = i; hit = 1'b1; return; end
      if (auto_m) begin
        tcnt++;
        if (tcnt == TO) begin k = i; return; end
      end
    end
  endtask

  task automatic feed_frame(input string tag, input int p, input bit edg, input bit auto_m,
                            input int gap, input int arm_at, input int done_at);
    int k, nacc, cyc, fr0;
    bit hit, got;
    find_trig(p, 8'h80, edg, auto_m, k, hit);
    nacc = 0; cyc = 0; got = 1'b0; fr0 = fr_cnt;
    while (!got && cyc < 3000) begin
      sample_valid = (cyc % gap == 0);
      sample_data  = stim[nacc % 1024];
      arm          = sample_valid && (nacc == arm_at);
      rd_done      = sample_valid && (nacc == done_at);
      step();
      if (sample_valid) nacc++;
      cyc++;
      if (frame_ready === 1'b1) got = 1'b1;
    end
    arm = 1'b0; rd_done = 1'b0;
    chk({tag, " frame_ready seen"}, got, 1);
    chk({tag, " sample count"}, nacc, k + DP - p);
    chk({tag, " frame_trig"}, frame_trig, hit);
    sample_valid = 1'b1; sample_data = 8'hAA;
    step();
    sample_valid = 1'b0;
    chk({tag, " single pulse"}, fr_cnt - fr0, 1);
    chk({tag, " hold state"}, state_o, 5);
    for (int i = 0; i <= DP; i++) begin
      rd_addr = (i == DP) ? AW'(20) : AW'(i);
      exp_q.push_back(stim[k - p + ((i == DP) ? 0 : i)]);
      step();
      chk($sformatf("%s rd[%0d]", tag, rd_addr), rd_data, exp_q.pop_front());
    end
  endtask

  task automatic feed_noframe(input string tag, input int n);
    int fr0;
    fr0 = fr_cnt;
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data  = stim[i % 1024];
      step();
    end
    sample_valid = 1'b0;
    chk({tag, " no frame"}, fr_cnt - fr0, 0);
  endtask

  task automatic pulse_done();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    int cyc;
    // Rising trigger, normal mode; rd_done during ARMED is ignored.
    do_reset(3'd2);
    fill_ramp(0, 16);
    feed_frame("rise", 4, 1'b0, 1'b0, 1, -1, 6);
    pulse_done();
    chk("rise restart", state_o, 2);
    // Same frame with 1-in-3 valid gaps; next frame configured falling.
    feed_frame("gaps", 4, 1'b0, 1'b0, 3, -1, -1);
    trig_edge = 1'b1;
    pulse_done();
    fill_ramp(240, -16);
    feed_frame("fall", 4, 1'b1, 1'b0, 1, -1, -1);
    pulse_done();
    for (int i = 0; i < 1024; i++) stim[i] = (i < 256) ? 8'(i) : 8'hFF;
    feed_noframe("fall rising-input", 300);
    chk("fall still armed", state_o, 3);
    // Auto timeout with constant input, then normal mode never times out.
    trig_edge = 1'b0; trig_mode = 2'd0;
    do_reset(3'd2);
    fill_ramp(48, 0);
    feed_frame("auto", 4, 1'b0, 1'b1, 1, -1, -1);
    trig_mode = 2'd1;
    pulse_done();
    feed_noframe("normal const", 1000);
    // Single mode: arm required, arm while ARMED ignored, one frame per arm.
    trig_mode = 2'd2;
    do_reset(3'd1);
    fill_ramp(0, 16);
    feed_noframe("single unarmed", 5);
    chk("single waits", state_o, 1);
    pulse_arm();
    chk("single armed", state_o, 2);
    feed_frame("single1", 4, 1'b0, 1'b0, 1, 5, -1);
    pulse_done();
    chk("single wait again", state_o, 1);
    feed_noframe("single idle", 100);
    chk("single still waiting", state_o, 1);
    pulse_arm();
    feed_frame("single2", 4, 1'b0, 1'b0, 1, -1, -1);
    rd_done = 1'b1; arm = 1'b1;
    step();
    rd_done = 1'b0; arm = 1'b0;
    chk("done+arm state", state_o, 1);
    feed_noframe("done+arm", 20);
    chk("arm not remembered", state_o, 1);
    // Pre-trigger limits: zero and clamped with start wrap.
    trig_mode = 2'd1; pre_trig = 6'd0;
    do_reset(3'd2);
    feed_frame("pre0", 0, 1'b0, 1'b0, 1, -1, -1);
    pre_trig = 6'd50;
    do_reset(3'd2);
    feed_frame("pre50", 15, 1'b0, 1'b0, 1, -1, -1);
    // Reset while collecting post-trigger samples.
    pre_trig = 6'd4;
    do_reset(3'd2);
    cyc = 0;
    while (state_o !== 3'd4 && cyc < 200) begin
      sample_valid = 1'b1;
      sample_data  = stim[cyc];
      step();
      cyc++;
    end
    chk("reached POST", state_o, 4);
    cyc = fr_cnt;
    rst_n = 1'b0;
    step();
    sample_valid = 1'b0;
    chk("mid-reset state", state_o, 0);
    chk("mid-reset frame_ready", frame_ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid-reset no frame", fr_cnt - cyc, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
